// File: rtl/pc_ctrl_if.sv
// Bus interface for pc_ctrl: start/halt controls, ALU zero input, branch
// controls, LUT loader path and the PC/status outputs.
// The master modport is the sequencer's environment (decoder, ALU, loader,
// top level); the slave modport is pc_ctrl itself.
interface pc_ctrl_if #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
);
  // Control inputs to the sequencer
  logic              start;
  logic              halt;
  logic              zero_in;
  logic              flag_we;
  logic              br_en;
  logic [1:0]        br_cond;
  logic [LUT_AW-1:0] br_idx;

  // Branch-target LUT loader path
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [PC_W-1:0]   lut_data;

  // Outputs from the sequencer
  logic [PC_W-1:0]   pc;
  logic              zero_flag;
  logic              running;
  logic              done;

  modport master (
    output start, halt, zero_in, flag_we, br_en, br_cond, br_idx,
    output lut_we, lut_addr, lut_data,
    input  pc, zero_flag, running, done
  );

  modport slave (
    input  start, halt, zero_in, flag_we, br_en, br_cond, br_idx,
    input  lut_we, lut_addr, lut_data,
    output pc, zero_flag, running, done
  );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-side program counter sequencer.
// Holds the registered ALU zero flag, a 2^LUT_AW-entry branch-target LUT and
// an IDLE/RUN/DONE state machine driving the PC for instruction memory.
//
// Optional build macro ZERO_BYPASS_EN: when defined, a cycle with both
// flag_we and br_en evaluates the branch condition against zero_in directly
// (compare-and-branch in one instruction). When undefined, branches always
// see the registered zero_flag.
//
// Handshake: start is a one-cycle pulse accepted only in IDLE or DONE; the
// sequencer answers with running=1 from the next cycle until a halt is
// decoded, after which done=1 is held until the next start. There is no
// back-pressure: start is never stalled, and start seen in RUN is dropped.
module pc_ctrl #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  pc_ctrl_if.slave   bus,
  output logic [1:0] state_o
);

  localparam int              LUT_N  = 1 << LUT_AW;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              flag_q, flag_d;
  logic [PC_W-1:0]   lut_q [LUT_N];

  logic              br_flag;
  logic              br_taken;
  logic [PC_W-1:0]   br_target;

  // Flag seen by the branch condition (optionally bypassed from the ALU)
  always_comb begin
`ifdef ZERO_BYPASS_EN
    br_flag = (bus.flag_we && bus.br_en) ? bus.zero_in : flag_q;
`else
    br_flag = flag_q;
`endif
  end

  // Decode the branch condition code against the selected flag
  always_comb begin
    br_taken = 1'b0;
    case (bus.br_cond)
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = br_flag;
      2'b10:   br_taken = ~br_flag;
      default: br_taken = 1'b0;
    endcase
  end

  // LUT read is combinational from registered contents, so a same-cycle
  // write is only visible to the following cycle's branch.
  assign br_target = lut_q[bus.br_idx];

  // Next-state, next-PC and next-flag logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          flag_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.flag_we) begin
          flag_d = bus.zero_in;
        end
        if (bus.halt) begin
          // halt wins over any branch; the PC keeps the halt address
          state_d = ST_DONE;
        end else if (bus.br_en && br_taken) begin
          pc_d = br_target;
        end else begin
          // natural modulo-2^PC_W wrap from all-ones to zero
          pc_d = pc_q + PC_ONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        flag_d  = 1'b0;
      end
    endcase
  end

  // State, PC and zero flag registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
    end
  end

  // Branch-target LUT: cleared on reset, one write per cycle in any state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.lut_we) begin
      lut_q[bus.lut_addr] <= bus.lut_data;
    end
  end

  // Moore outputs decoded from registered state
  assign bus.pc        = pc_q;
  assign bus.zero_flag = flag_q;
  assign bus.running   = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the sequencer.
module tb_pc_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam int PC_MOD = 1 << PC_W;

  logic       Clk;
  logic       Reset;
  logic [1:0] state_dbg;

  pc_ctrl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

  pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 running, 2 done
  int              m_mode;
  int              m_pc;
  int              m_flag;
  int              m_lut [LUT_N];
  logic [PC_W-1:0] exp_q [$];

  int n_vec;
  int n_err;

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    m_flag = 0;
    for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
    exp_q.delete();
  endtask

  function automatic int cond_true(input int cond, input int f);
    if (cond == 0) return 1;
    if (cond == 1) return f;
    if (cond == 2) return (f == 0) ? 1 : 0;
    return 0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    int f;
    int nxt_flag;
    nxt_flag = m_flag;
    if (m_mode == 0) begin
      if (bus.start) begin
        m_mode   = 1;
        m_pc     = 0;
        nxt_flag = 0;
      end
    end else if (m_mode == 1) begin
      f = m_flag;
`ifdef ZERO_BYPASS_EN
      if (bus.flag_we && bus.br_en) f = int'(bus.zero_in);
`endif
      if (bus.flag_we) nxt_flag = int'(bus.zero_in);
      if (bus.halt) begin
        m_mode = 2;
      end else if (bus.br_en && cond_true(int'(bus.br_cond), f) != 0) begin
        m_pc = m_lut[bus.br_idx];
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end else begin
      if (bus.start) begin
        m_mode = 1;
        m_pc   = 0;
      end
    end
    m_flag = nxt_flag;
    if (bus.lut_we) m_lut[bus.lut_addr] = int'(bus.lut_data);
    exp_q.push_back(m_pc[PC_W-1:0]);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [PC_W-1:0] exp_pc;
    exp_pc = exp_q.pop_front();
    check("pc", 32'(bus.pc), 32'(exp_pc));
    check("zero_flag", 32'(bus.zero_flag), 32'(m_flag));
    check("running", 32'(bus.running), (m_mode == 1) ? 32'd1 : 32'd0);
    check("done", 32'(bus.done), (m_mode == 2) ? 32'd1 : 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.start    = 1'b0;
    bus.halt     = 1'b0;
    bus.zero_in  = 1'b0;
    bus.flag_we  = 1'b0;
    bus.br_en    = 1'b0;
    bus.br_cond  = 2'b00;
    bus.br_idx   = '0;
    bus.lut_we   = 1'b0;
    bus.lut_addr = '0;
    bus.lut_data = '0;
  endtask

  // One clock with the inputs as currently driven, then check 1 unit later.
  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    compare_outputs();
  endtask

  task automatic tick();
    clear_inputs();
    cycle();
  endtask

  task automatic do_start();
    clear_inputs();
    bus.start = 1'b1;
    cycle();
  endtask

  task automatic do_flag(input logic z);
    clear_inputs();
    bus.flag_we = 1'b1;
    bus.zero_in = z;
    cycle();
  endtask

  task automatic do_branch(input logic [1:0] cond, input logic [LUT_AW-1:0] idx);
    clear_inputs();
    bus.br_en   = 1'b1;
    bus.br_cond = cond;
    bus.br_idx  = idx;
    cycle();
  endtask

  task automatic lut_write(input logic [LUT_AW-1:0] a, input logic [PC_W-1:0] d);
    clear_inputs();
    bus.lut_we   = 1'b1;
    bus.lut_addr = a;
    bus.lut_data = d;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    model_reset();
    Reset = 1'b0;
    #1;
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_flag", 32'(bus.zero_flag), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;

    // Idle with stray controls: nothing should move
    tick();
    clear_inputs();
    bus.halt = 1'b1; bus.flag_we = 1'b1; bus.zero_in = 1'b1; bus.br_en = 1'b1;
    cycle();

    // Load branch targets while idle
    lut_write(4'd3, 10'd200);
    lut_write(4'd7, 10'd1023);
    lut_write(4'd5, 10'd9);
    lut_write(4'd2, 10'd12);
    lut_write(4'd6, 10'd50);

    // Start and free-run: 0,1,2,3,4,5
    do_start();
    repeat (5) tick();

    // Conditional branches on a set flag
    do_flag(1'b1);
    do_branch(2'b01, 4'd3);  // taken -> 200
    do_branch(2'b10, 4'd3);  // not taken -> 201
    do_branch(2'b11, 4'd3);  // never -> 202

    // Wrap from 1023 to 0
    do_branch(2'b00, 4'd7);
    tick();

    // Same-cycle compare and branch with a clear registered flag
    do_flag(1'b0);
    clear_inputs();
    bus.flag_we = 1'b1; bus.zero_in = 1'b1;
    bus.br_en = 1'b1; bus.br_cond = 2'b01; bus.br_idx = 4'd2;
    cycle();

    // LUT write racing a branch on the same entry: old value then new
    clear_inputs();
    bus.lut_we = 1'b1; bus.lut_addr = 4'd5; bus.lut_data = 10'd77;
    bus.br_en = 1'b1; bus.br_cond = 2'b00; bus.br_idx = 4'd5;
    cycle();
    do_branch(2'b00, 4'd5);

    // Halt together with a branch at pc 50
    do_branch(2'b00, 4'd6);
    clear_inputs();
    bus.halt = 1'b1; bus.br_en = 1'b1; bus.br_cond = 2'b00; bus.br_idx = 4'd3;
    cycle();
    clear_inputs();
    bus.br_en = 1'b1; bus.flag_we = 1'b1; bus.zero_in = ~bus.zero_flag;
    cycle();
    tick();
    do_start();
    tick();

    // Async reset mid-run at pc 37
    repeat (36) tick();
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check("async_pc", 32'(bus.pc), 32'd0);
    check("async_running", 32'(bus.running), 32'd0);
    check("async_done", 32'(bus.done), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) tick();
    do_start();
    do_branch(2'b00, 4'd3);  // LUT was cleared -> 0

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      bus.start    = ($urandom_range(0, 15) == 0);
      bus.halt     = ($urandom_range(0, 39) == 0);
      bus.zero_in  = 1'($urandom_range(0, 1));
      bus.flag_we  = ($urandom_range(0, 2) == 0);
      bus.br_en    = ($urandom_range(0, 3) == 0);
      bus.br_cond  = 2'($urandom_range(0, 3));
      bus.br_idx   = LUT_AW'($urandom_range(0, LUT_N - 1));
      bus.lut_we   = ($urandom_range(0, 7) == 0);
      bus.lut_addr = LUT_AW'($urandom_range(0, LUT_N - 1));
      bus.lut_data = PC_W'($urandom_range(0, PC_MOD - 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
